tuner_ctrl: RTL and testbench

TUNER_CTRL -- requirements
Module: tuner_ctrl

---
 rtl/tuner_ctrl.sv | 129 ++++++++++++
 tb/tb_tuner_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tuner_ctrl.sv
// Capture/analyse controller: loads a frame, kicks the FFT, then scans the magnitude
// RAM for the largest non-DC bin and reports it with a one-cycle result_valid pulse.
module tuner_ctrl #(
    parameter int N_POINTS    = 1024,
    parameter int MIN_BIN     = 1,
    parameter int FFT_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        do_load,
    input  logic        data_loaded,
    output logic        fft_start,
    input  logic        fft_done,
    output logic [10:0] rd_addr,
    input  logic [9:0]  rd_data,
    output logic [9:0]  peak_bin,
    output logic [9:0]  peak_mag,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int          CW         = $clog2(FFT_TIMEOUT) + 1;
    localparam logic [10:0] FIRST_ADDR = 11'(MIN_BIN);
    localparam logic [10:0] LAST_ADDR  = 11'(N_POINTS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FFT_KICK,
        FFT_WAIT,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  wait_cnt;
    logic           wait_expired;
    logic [9:0]     tag_bin;
    logic           tag_vld;
    logic [9:0]     max_bin;
    logic [9:0]     max_mag;
    logic           sample_wins;

    assign wait_expired = (wait_cnt == CW'(FFT_TIMEOUT - 1));
    // Strictly greater keeps the lowest bin on a tie.
    assign sample_wins  = tag_vld && (rd_data > max_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     if (data_loaded) state_nxt = FFT_KICK;
            FFT_KICK: state_nxt = FFT_WAIT;
            FFT_WAIT: begin
                if (fft_done) begin
                    state_nxt = SCAN;
                end else if (wait_expired) begin
                    state_nxt = IDLE;
                end
            end
            SCAN:     if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign do_load      = (state == LOAD);
    assign fft_start    = (state == FFT_KICK);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            rd_addr     <= '0;
            tag_bin     <= '0;
            tag_vld     <= 1'b0;
            max_bin     <= '0;
            max_mag     <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // RAM returns data one cycle after the address, so tag it with the previous address.
            tag_bin     <= rd_addr[9:0];
            tag_vld     <= (state == SCAN);
            timeout_err <= (state == FFT_WAIT) && !fft_done && wait_expired;

            if (state == FFT_KICK) begin
                wait_cnt <= '0;
            end else if (state == FFT_WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if ((state == FFT_WAIT) && fft_done) begin
                rd_addr <= FIRST_ADDR;
                max_bin <= '0;
                max_mag <= '0;
            end else begin
                if ((state == SCAN) && (rd_addr != LAST_ADDR)) begin
                    rd_addr <= rd_addr + 11'(1);
                end
                if (((state == SCAN) || (state == DRAIN)) && sample_wins) begin
                    max_bin <= tag_bin;
                    max_mag <= rd_data;
                end
            end

            // The final sample arrives in DRAIN, so fold it in while publishing.
            if (state == DRAIN) begin
                peak_bin <= sample_wins ? tag_bin : max_bin;
                peak_mag <= sample_wins ? rd_data : max_mag;
            end
        end
    end

endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed bench for tuner_ctrl with a behavioural synchronous magnitude RAM.
module tb_tuner_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        do_load;
    logic        data_loaded;
    logic        fft_start;
    logic        fft_done;
    logic [10:0] rd_addr;
    logic [9:0]  rd_data;
    logic [9:0]  peak_bin;
    logic [9:0]  peak_mag;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] mem [0:511];

    tuner_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .do_load      (do_load),
        .data_loaded  (data_loaded),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr[8:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [9:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] agg;
        agg = {do_load, fft_start, result_valid, timeout_err, busy,
               rd_addr, peak_bin, peak_mag} != 0;
        chk(tag, agg, 0);
    endtask

    // Start a cycle and walk it through LOAD and FFT_KICK; ends at the first FFT_WAIT cycle.
    task automatic kick(input int load_wait);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("load_do_load", do_load, 1);
        chk("load_busy", busy, 1);
        if (!data_loaded) begin
            repeat (load_wait - 1) @(negedge clk);
            chk("load_still_waiting", do_load, 1);
            data_loaded = 1'b1;
            @(negedge clk) data_loaded = 1'b0;
        end else begin
            @(negedge clk);
        end
        chk("kick_fft_start", fft_start, 1);
        chk("kick_do_load_off", do_load, 0);
        @(negedge clk);
        chk("wait_fft_start_off", fft_start, 0);
    endtask

    // Raise fft_done in FFT_WAIT cycle done_wait-1, then check latency and result.
    task automatic finish_scan(input int done_wait, input int exp_bin, input int exp_mag);
        int n;
        repeat (done_wait - 1) @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk) fft_done = 1'b0;
        chk("scan_first_addr", rd_addr, 1);
        chk("scan_no_timeout", timeout_err, 0);
        n = 1;
        while (!result_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("result_latency", n, 513);
        chk("peak_bin", peak_bin, exp_bin);
        chk("peak_mag", peak_mag, exp_mag);
        @(negedge clk);
        chk("result_valid_pulse", result_valid, 0);
        chk("idle_after_done", busy, 0);
        chk("rd_addr_holds", rd_addr, 511);
    endtask

    initial begin
        int n;
        int bad;
        rst         = 1'b1;
        start       = 1'b0;
        data_loaded = 1'b0;
        fft_done    = 1'b0;
        fill(10'd100);
        mem[82] = 10'd700;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_action", busy, 0);

        // Nominal frame.
        kick(1024);
        finish_scan(10, 82, 700);

        // Ties and DC: bin 0 is never scanned, lowest tied bin wins.
        fill(10'd10);
        mem[0]   = 10'd1023;
        mem[40]  = 10'd500;
        mem[300] = 10'd500;
        kick(5);
        finish_scan(10, 40, 500);

        // Asynchronous reset mid-scan.
        kick(5);
        repeat (9) @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk) fft_done = 1'b0;
        n = 0;
        while (rd_addr != 11'd200 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_addr_200", rd_addr, 200);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_reset_mid_scan");
        @(negedge clk) rst = 1'b0;
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (result_valid || busy) bad++;
        end
        chk("no_action_after_reset", bad, 0);
        kick(5);
        finish_scan(10, 40, 500);

        // Timeout: fft_done never arrives.
        kick(5);
        n = 0;
        while (!timeout_err && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, 4096);
        chk("timeout_busy_low", busy, 0);
        chk("timeout_no_result", result_valid, 0);
        chk("timeout_keeps_bin", peak_bin, 40);
        chk("timeout_keeps_mag", peak_mag, 500);
        @(negedge clk);
        chk("timeout_pulse_one", timeout_err, 0);

        // fft_done on the very cycle the wait expires takes priority.
        fill(10'd3);
        mem[511] = 10'd9;
        kick(5);
        finish_scan(4096, 511, 9);

        // Sticky loader with an all-zero RAM.
        fill(10'd0);
        data_loaded = 1'b1;
        kick(5);
        finish_scan(10, 0, 0);
        data_loaded = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
